// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte producers share one UART hex formatter.
// One transmission is in flight at a time; completion comes from the formatter's busy flag or an accept timeout.
module uart_tx_arbiter #(
    parameter int N_REQ          = 3,
    parameter int DATA_W         = 8,
    parameter int ACCEPT_TIMEOUT = 16,
    parameter int GAP_CYCLES     = 0,
    parameter int ID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    arb_busy
);
    localparam int CNT_MAX  = (ACCEPT_TIMEOUT > GAP_CYCLES) ? ACCEPT_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int CW       = ID_W + 1;
    localparam int SLOTS    = 1 << ID_W;
    localparam int PAD      = 1 << CW;
    localparam int TO_LAST  = (ACCEPT_TIMEOUT > 0) ? ACCEPT_TIMEOUT - 1 : 0;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } state_t;

    state_t            state_reg;
    logic [ID_W-1:0]   last_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [DATA_W-1:0] req_slice [SLOTS];
    logic [PAD-1:0]    valid_pad;
    logic [CW-1:0]     cand;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;

    // Unused slots read as zero so the byte mux is indexed over a full power of two.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slice
            if (gi < N_REQ) begin : g_real
                assign req_slice[gi] = req_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign req_slice[gi] = '0;
            end
        end
    endgenerate

    assign valid_pad = PAD'(req_valid);

    // Walk from farthest to nearest after last_reg so the nearest valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, last_reg} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (valid_pad[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            tx_start  <= 1'b0;
            req_ack   <= '0;
            tx_data   <= '0;
            grant_id  <= '0;
            arb_busy  <= 1'b0;
            last_reg  <= ID_W'(N_REQ - 1);
            cnt_reg   <= '0;
        end else begin
            tx_start <= 1'b0;
            req_ack  <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (win_found && !tx_busy) begin
                        state_reg <= S_ISSUE;
                        tx_data   <= req_slice[win_idx];
                        grant_id  <= win_idx;
                        last_reg  <= win_idx;
                        arb_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    tx_start  <= 1'b1;
                    req_ack   <= N_REQ'(1) << grant_id;
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        state_reg <= S_WAIT_LO;
                    end else if (cnt_reg == CNT_W'(TO_LAST)) begin
                        cnt_reg <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_reg <= S_IDLE;
                            arb_busy  <= 1'b0;
                        end else begin
                            state_reg <= S_GAP;
                        end
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        cnt_reg <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_reg <= S_IDLE;
                            arb_busy  <= 1'b0;
                        end else begin
                            state_reg <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_reg == CNT_W'(GAP_LAST)) begin
                        state_reg <= S_IDLE;
                        arb_busy  <= 1'b0;
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    arb_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a default instance plus one with GAP_CYCLES = 4,
// a behavioural formatter model, and a round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int N   = 3;
    localparam int W   = 8;
    localparam int ID  = 2;
    localparam int AT  = 16;
    localparam int GAP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy;
    logic [ID-1:0]  grant_id;
    logic           arb_busy;

    logic [N-1:0]   g_req_valid;
    logic [N*W-1:0] g_req_data;
    logic [N-1:0]   g_req_ack;
    logic           g_tx_start;
    logic [W-1:0]   g_tx_data;
    logic           g_tx_busy;
    logic [ID-1:0]  g_grant_id;
    logic           g_arb_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_starts = 0;
    int model_last = N - 1;

    bit   fmt_en = 1'b0;
    int   fmt_dly = 1;
    int   fmt_len = 1;
    int   pend = 0;
    int   rem = 0;
    logic model_busy = 1'b0;
    logic man_busy = 1'b0;
    assign tx_busy = model_busy | man_busy;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .ACCEPT_TIMEOUT(AT), .GAP_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy)
    );

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .ACCEPT_TIMEOUT(AT), .GAP_CYCLES(GAP)) u_gap (
        .clk(clk), .rst(rst), .req_valid(g_req_valid), .req_data(g_req_data), .req_ack(g_req_ack),
        .tx_start(g_tx_start), .tx_data(g_tx_data), .tx_busy(g_tx_busy), .grant_id(g_grant_id), .arb_busy(g_arb_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Formatter: raises busy fmt_dly cycles after seeing tx_start, for fmt_len cycles.
    always @(posedge clk) begin
        #1;
        if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0) model_busy = 1'b0;
        end
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                model_busy = 1'b1;
                rem = fmt_len;
            end
        end
        if (fmt_en && tx_start === 1'b1) pend = fmt_dly;
    end

    // Every start must carry exactly the one-hot ack of the granted requester.
    always @(negedge clk) begin
        if (tx_start === 1'b1 || req_ack !== '0) begin
            n_tests++;
            if (!(tx_start === 1'b1 && req_ack === (N'(1) << grant_id))) begin
                n_fail++;
                $display("[TB] FAIL ack_coincide: got start=%b ack=%b gid=%0d, need start=1 with one-hot ack of gid", tx_start, req_ack, grant_id);
            end
            if (tx_start === 1'b1) n_starts++;
        end
        if (g_tx_start === 1'b1 || g_req_ack !== '0) begin
            n_tests++;
            if (!(g_tx_start === 1'b1 && g_req_ack === (N'(1) << g_grant_id))) begin
                n_fail++;
                $display("[TB] FAIL gap_ack_coincide: got start=%b ack=%b gid=%0d, need start=1 with one-hot ack of gid", g_tx_start, g_req_ack, g_grant_id);
            end
        end
    end

    // Reference round robin: lowest valid index above last, otherwise lowest valid overall.
    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int i = last + 1; i < N; i++) if (mask[i]) return i;
        for (int i = 0; i <= last; i++) if (mask[i]) return i;
        return -1;
    endfunction

    task automatic goto_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_start(input bit gap_dut, input int budget, output bit ok, output int c);
        ok = 1'b0;
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((gap_dut ? g_tx_start : tx_start) === 1'b1) begin
                ok = 1'b1;
                c = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (arb_busy === 1'b0 && tx_busy === 1'b0 && g_arb_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL idle_timeout: arb_busy=%b tx_busy=%b g_arb_busy=%b, need all 0 within 500 cycles", arb_busy, tx_busy, g_arb_busy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_last = N - 1;
    endtask

    task automatic test_reset();
        bit ok;
        int c, v0;
        fmt_en = 1'b1; fmt_dly = 2; fmt_len = 5;
        rst = 1'b0;
        req_data = {8'h33, 8'h22, 8'h11};
        req_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({tx_start, req_ack, tx_data, grant_id, arb_busy, g_tx_start, g_req_ack, g_tx_data, g_grant_id, g_arb_busy} !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_values: got start=%b ack=%b data=%h gid=%0d busy=%b (gap dut start=%b busy=%b), need all 0",
                         tx_start, req_ack, tx_data, grant_id, arb_busy, g_tx_start, g_arb_busy);
            end
        end
        rst = 1'b1;
        v0 = cyc;
        wait_start(1'b0, 10, ok, c);
        n_tests++;
        if (!ok || c != v0 + 2) begin
            n_fail++;
            $display("[TB] FAIL reset_first_latency: got start at cycle %0d, need %0d", c, v0 + 2);
        end
        n_tests++;
        if (grant_id !== 2'd0 || tx_data !== 8'h11 || req_ack !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL reset_first_grant: got gid=%0d data=%h ack=%b, need gid=0 data=11 ack=001", grant_id, tx_data, req_ack);
        end
        model_last = 0;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_single();
        bit ok;
        int c, v0, s0;
        wait_idle();
        fmt_en = 1'b1; fmt_dly = 2; fmt_len = 100;
        @(negedge clk);
        req_data = {W'($urandom), 8'hA5, W'($urandom)};
        req_valid = 3'b010;
        v0 = cyc;
        s0 = n_starts;
        wait_start(1'b0, 10, ok, c);
        n_tests++;
        if (!ok || c != v0 + 2) begin
            n_fail++;
            $display("[TB] FAIL single_latency: got start at cycle %0d, need %0d", c, v0 + 2);
        end
        n_tests++;
        if (tx_data !== 8'hA5 || req_ack !== 3'b010 || grant_id !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got data=%h ack=%b gid=%0d, need data=a5 ack=010 gid=1", tx_data, req_ack, grant_id);
        end
        model_last = 1;
        req_valid = '0;
        goto_cyc(c + 102);
        n_tests++;
        if (arb_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_busy_hold: got arb_busy=%b on the cycle busy falls, need 1", arb_busy);
        end
        @(negedge clk);
        n_tests++;
        if (arb_busy !== 1'b0 || tx_data !== 8'hA5 || n_starts != s0 + 1) begin
            n_fail++;
            $display("[TB] FAIL single_release: got arb_busy=%b data=%h starts=%0d, need 0, a5, %0d", arb_busy, tx_data, n_starts - s0, 1);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int c, e;
        logic [W-1:0] exp_data;
        wait_idle();
        do_reset();
        fmt_en = 1'b1; fmt_dly = 1; fmt_len = 3;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        req_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
            wait_start(1'b0, 100, ok, c);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL rr_start: got no tx_start for transfer %0d, need one", t);
                break;
            end
            e = rr_pick(req_valid, model_last);
            exp_data = req_data[e*W +: W];
            if (grant_id !== ID'(e) || tx_data !== exp_data) begin
                n_fail++;
                $display("[TB] FAIL rr_order: transfer %0d got gid=%0d data=%h, need gid=%0d data=%h", t, grant_id, tx_data, e, exp_data);
            end
            model_last = e;
            req_data[e*W +: W] = W'($urandom);
        end
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_random();
        bit ok;
        int c, e;
        logic [N-1:0] mask, new_bits, exp_ack;
        logic [W-1:0] exp_data;
        fmt_en = 1'b1; fmt_dly = 1; fmt_len = 2;
        @(negedge clk);
        mask = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        req_valid = mask;
        for (int t = 0; t < 24; t++) begin
            wait_start(1'b0, 200, ok, c);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL rand_start: got no tx_start for transfer %0d mask=%b, need one", t, mask);
                break;
            end
            e = rr_pick(mask, model_last);
            exp_data = req_data[e*W +: W];
            exp_ack = N'(1) << e;
            if (grant_id !== ID'(e) || tx_data !== exp_data || req_ack !== exp_ack) begin
                n_fail++;
                $display("[TB] FAIL rand_grant: transfer %0d mask=%b got gid=%0d data=%h ack=%b, need gid=%0d data=%h ack=%b",
                         t, mask, grant_id, tx_data, req_ack, e, exp_data, exp_ack);
            end
            model_last = e;
            mask[e] = 1'b0;
            new_bits = N'($urandom_range(0, (1 << N) - 1)) & ~mask;
            if ((mask | new_bits) == '0) new_bits = N'(1) << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) if (new_bits[i]) req_data[i*W +: W] = W'($urandom);
            mask = mask | new_bits;
            req_valid = mask;
            fmt_dly = $urandom_range(1, 3);
            fmt_len = $urandom_range(1, 6);
        end
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_timeout();
        bit ok;
        int c, c2;
        logic [W-1:0] d2, d0;
        wait_idle();
        fmt_en = 1'b0;
        @(negedge clk);
        d2 = W'($urandom);
        d0 = W'($urandom);
        req_data = {d2, W'($urandom), d0};
        req_valid = 3'b100;
        wait_start(1'b0, 10, ok, c);
        n_tests++;
        if (!ok || grant_id !== 2'd2 || tx_data !== d2) begin
            n_fail++;
            $display("[TB] FAIL timeout_grant: got ok=%0d gid=%0d data=%h, need gid=2 data=%h", ok, grant_id, tx_data, d2);
        end
        model_last = 2;
        req_valid = 3'b001;
        goto_cyc(c + AT - 1);
        n_tests++;
        if (arb_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_early: got arb_busy=%b %0d cycles after start, need 1", arb_busy, AT - 1);
        end
        @(negedge clk);
        n_tests++;
        if (arb_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_exit: got arb_busy=%b %0d cycles after start, need 0", arb_busy, AT);
        end
        fmt_en = 1'b1; fmt_dly = 1; fmt_len = 2;
        wait_start(1'b0, 10, ok, c2);
        n_tests++;
        if (!ok || c2 != c + AT + 2 || grant_id !== 2'd0 || tx_data !== d0) begin
            n_fail++;
            $display("[TB] FAIL timeout_next: got start cycle %0d gid=%0d data=%h, need cycle %0d gid=0 data=%h", c2, grant_id, tx_data, c + AT + 2, d0);
        end
        model_last = 0;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_busy_idle();
        bit ok;
        int c, f;
        logic [W-1:0] d0;
        wait_idle();
        fmt_en = 1'b1; fmt_dly = 1; fmt_len = 2;
        @(negedge clk);
        d0 = W'($urandom);
        req_data[0 +: W] = d0;
        man_busy = 1'b1;
        req_valid = 3'b001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (tx_start !== 1'b0 || arb_busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL busy_idle_block: got start=%b arb_busy=%b while tx_busy high, need 0 0", tx_start, arb_busy);
            end
        end
        man_busy = 1'b0;
        f = cyc;
        wait_start(1'b0, 10, ok, c);
        n_tests++;
        if (!ok || c != f + 2 || grant_id !== 2'd0 || tx_data !== d0) begin
            n_fail++;
            $display("[TB] FAIL busy_idle_release: got start cycle %0d gid=%0d data=%h, need cycle %0d gid=0 data=%h", c, grant_id, tx_data, f + 2, d0);
        end
        model_last = 0;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_gap();
        bit ok;
        int c, c2, f;
        logic [W-1:0] d0, d1;
        wait_idle();
        @(negedge clk);
        d0 = W'($urandom);
        d1 = W'($urandom);
        g_req_data = {W'($urandom), d1, d0};
        g_req_valid = 3'b001;
        wait_start(1'b1, 10, ok, c);
        n_tests++;
        if (!ok || g_grant_id !== 2'd0 || g_tx_data !== d0) begin
            n_fail++;
            $display("[TB] FAIL gap_first: got ok=%0d gid=%0d data=%h, need gid=0 data=%h", ok, g_grant_id, g_tx_data, d0);
        end
        g_req_valid = 3'b010;
        @(negedge clk);
        g_tx_busy = 1'b1;
        goto_cyc(c + 6);
        g_tx_busy = 1'b0;
        f = cyc;
        goto_cyc(f + GAP);
        n_tests++;
        if (g_arb_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gap_hold: got arb_busy=%b %0d cycles after busy fell, need 1", g_arb_busy, GAP);
        end
        @(negedge clk);
        n_tests++;
        if (g_arb_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gap_exit: got arb_busy=%b %0d cycles after busy fell, need 0", g_arb_busy, GAP + 1);
        end
        wait_start(1'b1, 10, ok, c2);
        n_tests++;
        if (!ok || c2 != f + GAP + 3 || g_grant_id !== 2'd1 || g_tx_data !== d1) begin
            n_fail++;
            $display("[TB] FAIL gap_next: got start cycle %0d gid=%0d data=%h, need cycle %0d gid=1 data=%h", c2, g_grant_id, g_tx_data, f + GAP + 3, d1);
        end
        g_req_valid = '0;
        goto_cyc(c2 + AT + GAP - 1);
        n_tests++;
        if (g_arb_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gap_timeout_early: got arb_busy=%b, need 1", g_arb_busy);
        end
        @(negedge clk);
        n_tests++;
        if (g_arb_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gap_timeout_exit: got arb_busy=%b %0d cycles after start, need 0", g_arb_busy, AT + GAP);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c, c2;
        logic [W-1:0] d2, d0;
        wait_idle();
        fmt_en = 1'b1; fmt_dly = 1; fmt_len = 50;
        @(negedge clk);
        d2 = W'($urandom) | 8'h80;
        d0 = W'($urandom);
        req_data = {d2, W'($urandom), d0};
        req_valid = 3'b100;
        wait_start(1'b0, 10, ok, c);
        n_tests++;
        if (!ok || grant_id !== 2'd2 || tx_data !== d2) begin
            n_fail++;
            $display("[TB] FAIL midrst_grant: got ok=%0d gid=%0d data=%h, need gid=2 data=%h", ok, grant_id, tx_data, d2);
        end
        req_valid = '0;
        goto_cyc(c + 10);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({tx_start, req_ack, tx_data, grant_id, arb_busy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_values: got start=%b ack=%b data=%h gid=%0d busy=%b, need all 0", tx_start, req_ack, tx_data, grant_id, arb_busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_last = N - 1;
        req_valid = 3'b001;
        wait_start(1'b0, 80, ok, c2);
        n_tests++;
        if (!ok || c2 != c + 53 || grant_id !== 2'd0 || tx_data !== d0) begin
            n_fail++;
            $display("[TB] FAIL midrst_next: got start cycle %0d gid=%0d data=%h, need cycle %0d gid=0 data=%h", c2, grant_id, tx_data, c + 53, d0);
        end
        req_valid = '0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        g_req_valid = '0;
        g_req_data = '0;
        g_tx_busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_timeout();
        test_busy_idle();
        test_gap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at 1 ms, need completion");
        $fatal(1, "watchdog expired");
    end
endmodule
